move_request_ctrl: RTL and testbench

// - Requester side of the move-check interface: turns player cursor selections into move requests for board_validator.
// - Owns the committed 8x8 board and drives it to the validator's board_in.
// - Holds each request stable for a fixed latency, then samples the verdict.
// - Commits the validator's board on a valid verdict, toggles turn, and flags done/rejected.

---
 rtl/move_req_if.sv | 25 ++
 rtl/move_request_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_move_request_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_req_if.sv
// Request/verdict bus between the move requester and board_validator.
// The requester drives the committed board and the request; the validator answers.
interface move_req_if;
    logic [7:0][7:0][3:0] board;
    logic [2:0]           req_old_x;
    logic [2:0]           req_old_y;
    logic [2:0]           req_new_x;
    logic [2:0]           req_new_y;
    logic [3:0]           req_piece_type;
    logic                 req_active;
    logic [7:0][7:0][3:0] val_board_out;
    logic                 val_board_valid;

    modport master (
        output board, req_old_x, req_old_y, req_new_x, req_new_y,
               req_piece_type, req_active,
        input  val_board_out, val_board_valid
    );

    modport slave (
        input  board, req_old_x, req_old_y, req_new_x, req_new_y,
               req_piece_type, req_active,
        output val_board_out, val_board_valid
    );
endinterface

// File: rtl/move_request_ctrl.sv
// Requester for the move-check bus: turns cursor selections into move requests,
// owns the committed board, and commits or rejects on the validator's verdict.
module move_request_ctrl #(
    parameter int VALIDATE_LAT = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [2:0] cursor_x,
    input  logic [2:0] cursor_y,
    input  logic       select_pulse,
    input  logic       cancel_pulse,
    move_req_if.master req,
    output logic       sel_active,
    output logic [2:0] sel_x,
    output logic [2:0] sel_y,
    output logic       turn,
    output logic       move_done,
    output logic       move_rejected
);

    typedef logic [7:0][7:0][3:0] board_t;
    typedef enum logic [1:0] {PICK_SRC, PICK_DST, VALIDATE} state_t;

    localparam int CNT_W = (VALIDATE_LAT > 1) ? $clog2(VALIDATE_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALIDATE_LAT - 1);
    localparam logic [3:0] NO_PIECE = 4'hF;

    function automatic logic [3:0] back_rank(input int x);
        case (x)
            0, 7:    return 4'd0;
            1, 6:    return 4'd1;
            2, 5:    return 4'd2;
            3:       return 4'd3;
            default: return 4'd4;
        endcase
    endfunction

    function automatic board_t init_board();
        board_t b;
        b = '1;
        for (int x = 0; x < 8; x++) begin
            b[0][x] = back_rank(x);
            b[1][x] = 4'd5;
            b[6][x] = 4'd11;
            b[7][x] = back_rank(x) + 4'd6;
        end
        return b;
    endfunction

    localparam board_t INIT_BOARD = init_board();

    function automatic logic is_own(input logic [3:0] p, input logic t);
        return t ? (p >= 4'd6 && p <= 4'd11) : (p <= 4'd5);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    board_t           board_q, board_d;
    logic             turn_q, turn_d;
    logic             sel_active_q, sel_active_d;
    logic [2:0]       sel_x_q, sel_x_d, sel_y_q, sel_y_d;
    logic [3:0]       piece_q, piece_d;
    logic [2:0]       old_x_q, old_x_d, old_y_q, old_y_d;
    logic [2:0]       new_x_q, new_x_d, new_y_q, new_y_d;
    logic [3:0]       req_piece_q, req_piece_d;
    logic             req_active_q, req_active_d;
    logic             done_q, done_d, rej_q, rej_d;

    logic [3:0] cur_piece;
    logic       cur_own;
    logic       on_src;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PICK_SRC;
            cnt_q        <= '0;
            board_q      <= INIT_BOARD;
            turn_q       <= 1'b0;
            sel_active_q <= 1'b0;
            sel_x_q      <= '0;
            sel_y_q      <= '0;
            piece_q      <= NO_PIECE;
            old_x_q      <= '0;
            old_y_q      <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            req_piece_q  <= NO_PIECE;
            req_active_q <= 1'b0;
            done_q       <= 1'b0;
            rej_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            board_q      <= board_d;
            turn_q       <= turn_d;
            sel_active_q <= sel_active_d;
            sel_x_q      <= sel_x_d;
            sel_y_q      <= sel_y_d;
            piece_q      <= piece_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            req_piece_q  <= req_piece_d;
            req_active_q <= req_active_d;
            done_q       <= done_d;
            rej_q        <= rej_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        board_d      = board_q;
        turn_d       = turn_q;
        sel_active_d = sel_active_q;
        sel_x_d      = sel_x_q;
        sel_y_d      = sel_y_q;
        piece_d      = piece_q;
        old_x_d      = old_x_q;
        old_y_d      = old_y_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        req_piece_d  = req_piece_q;
        req_active_d = req_active_q;
        done_d       = 1'b0;
        rej_d        = 1'b0;

        // Ownership is always judged against the committed board, never the proposal.
        cur_piece = board_q[cursor_y][cursor_x];
        cur_own   = is_own(cur_piece, turn_q);
        on_src    = (cursor_x == sel_x_q) && (cursor_y == sel_y_q);

        case (state_q)
            PICK_SRC: begin
                if (select_pulse && !cancel_pulse && cur_own) begin
                    sel_active_d = 1'b1;
                    sel_x_d      = cursor_x;
                    sel_y_d      = cursor_y;
                    piece_d      = cur_piece;
                    state_d      = PICK_DST;
                end
            end
            PICK_DST: begin
                if (cancel_pulse || (select_pulse && on_src)) begin
                    sel_active_d = 1'b0;
                    state_d      = PICK_SRC;
                end else if (select_pulse && cur_own) begin
                    sel_x_d = cursor_x;
                    sel_y_d = cursor_y;
                    piece_d = cur_piece;
                end else if (select_pulse) begin
                    old_x_d      = sel_x_q;
                    old_y_d      = sel_y_q;
                    new_x_d      = cursor_x;
                    new_y_d      = cursor_y;
                    req_piece_d  = piece_q;
                    req_active_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = VALIDATE;
                end
            end
            VALIDATE: begin
                // Request stays frozen until the validator pipeline has had its full latency.
                if (cnt_q == CNT_LAST) begin
                    if (req.val_board_valid) begin
                        board_d = req.val_board_out;
                        turn_d  = ~turn_q;
                        done_d  = 1'b1;
                    end else begin
                        rej_d = 1'b1;
                    end
                    req_active_d = 1'b0;
                    sel_active_d = 1'b0;
                    req_piece_d  = NO_PIECE;
                    state_d      = PICK_SRC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = PICK_SRC;
        endcase
    end

    assign req.board          = board_q;
    assign req.req_old_x      = old_x_q;
    assign req.req_old_y      = old_y_q;
    assign req.req_new_x      = new_x_q;
    assign req.req_new_y      = new_y_q;
    assign req.req_piece_type = req_piece_q;
    assign req.req_active     = req_active_q;

    assign sel_active    = sel_active_q;
    assign sel_x         = sel_x_q;
    assign sel_y         = sel_y_q;
    assign turn          = turn_q;
    assign move_done     = done_q;
    assign move_rejected = rej_q;

endmodule

// File: tb/tb_move_request_ctrl.sv
// Bench for move_request_ctrl: directed scenarios plus randomized play checked
// against a behavioural model of the selection/request/verdict rules.
module tb_move_request_ctrl;
    localparam int LAT = 2;
    typedef logic [7:0][7:0][3:0] board_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cx = '0, cy = '0;
    logic       sp = 1'b0, cp = 1'b0;
    logic       sel_active, turn, move_done, move_rejected;
    logic [2:0] sel_x, sel_y;

    move_req_if bus();

    move_request_ctrl #(.VALIDATE_LAT(LAT)) dut (
        .CLOCK_50      (clk),
        .reset_n       (rst_n),
        .cursor_x      (cx),
        .cursor_y      (cy),
        .select_pulse  (sp),
        .cancel_pulse  (cp),
        .req           (bus),
        .sel_active    (sel_active),
        .sel_x         (sel_x),
        .sel_y         (sel_y),
        .turn          (turn),
        .move_done     (move_done),
        .move_rejected (move_rejected)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model of the requester.
    board_t m_board;
    bit     m_turn, m_held, m_ra, m_done, m_rej;
    int     m_sx, m_sy, m_piece, m_wait;
    int     m_ox, m_oy, m_nx, m_ny, m_type;
    bit     v_valid;

    function automatic board_t start_board();
        int     back[8] = '{0, 1, 2, 3, 4, 2, 1, 0};
        board_t b;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                case (y)
                    0:       b[y][x] = 4'(back[x]);
                    1:       b[y][x] = 4'd5;
                    6:       b[y][x] = 4'd11;
                    7:       b[y][x] = 4'(back[x] + 6);
                    default: b[y][x] = 4'd15;
                endcase
        return b;
    endfunction

    function automatic void model_reset();
        m_board = start_board();
        m_turn = 0; m_held = 0; m_ra = 0; m_done = 0; m_rej = 0;
        m_sx = 0; m_sy = 0; m_piece = 15; m_wait = -1;
        m_ox = 0; m_oy = 0; m_nx = 0; m_ny = 0; m_type = 15;
    endfunction

    function automatic bit own(int p);
        return m_turn ? (p >= 6 && p <= 11) : (p >= 0 && p <= 5);
    endfunction

    // Validator stand-in: slide the requested piece from old to new square.
    function automatic board_t proposed();
        board_t b;
        b = m_board;
        b[m_ny][m_nx] = m_board[m_oy][m_ox];
        b[m_oy][m_ox] = 4'd15;
        return b;
    endfunction

    function automatic void model_edge(bit s, bit c, int x, int y, bit vv, board_t vb);
        int p;
        m_done = 0;
        m_rej  = 0;
        if (m_wait >= 0) begin
            if (m_wait == LAT - 1) begin
                if (vv) begin
                    m_board = vb;
                    m_turn  = !m_turn;
                    m_done  = 1;
                end else begin
                    m_rej = 1;
                end
                m_ra = 0; m_held = 0; m_type = 15; m_wait = -1;
            end else begin
                m_wait++;
            end
        end else if (c) begin
            m_held = 0;
        end else if (s) begin
            p = int'(m_board[y][x]);
            if (!m_held) begin
                if (own(p)) begin m_held = 1; m_sx = x; m_sy = y; m_piece = p; end
            end else if (x == m_sx && y == m_sy) begin
                m_held = 0;
            end else if (own(p)) begin
                m_sx = x; m_sy = y; m_piece = p;
            end else begin
                m_ox = m_sx; m_oy = m_sy; m_nx = x; m_ny = y;
                m_type = m_piece; m_ra = 1; m_wait = 0;
            end
        end
    endfunction

    task automatic step(bit s, bit c, int x, int y);
        sp = s; cp = c; cx = x[2:0]; cy = y[2:0];
        bus.val_board_out   = proposed();
        bus.val_board_valid = v_valid;
        model_edge(s, c, x, y, v_valid, proposed());
        @(posedge clk);
        #1;
        sp = 1'b0; cp = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; sp = 1'b0; cp = 1'b0; v_valid = 1'b0;
        bus.val_board_out = '1; bus.val_board_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.board !== start_board()) begin n_fail++; $display("FAIL reset_board: got %h want %h", bus.board, start_board()); end
        n_cmp++; if (turn !== 1'b0) begin n_fail++; $display("FAIL reset_turn: got %b want 0", turn); end
        n_cmp++; if (bus.req_active !== 1'b0) begin n_fail++; $display("FAIL reset_req_active: got %b want 0", bus.req_active); end
        n_cmp++; if ({move_done, move_rejected, sel_active} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {move_done, move_rejected, sel_active}); end
        n_cmp++; if (bus.req_piece_type !== 4'd15) begin n_fail++; $display("FAIL reset_piece: got %0d want 15", bus.req_piece_type); end
    endtask

    task automatic test_valid_move();
        apply_reset();
        v_valid = 1'b1;
        step(1, 0, 4, 1);
        n_cmp++; if ({sel_active, sel_x, sel_y} !== {1'b1, 3'd4, 3'd1}) begin n_fail++; $display("FAIL vm_sel: got %b want 1_100_001", {sel_active, sel_x, sel_y}); end
        step(1, 0, 4, 3);
        n_cmp++; if ({bus.req_old_x, bus.req_old_y, bus.req_new_x, bus.req_new_y} !== {3'd4, 3'd1, 3'd4, 3'd3}) begin n_fail++; $display("FAIL vm_coords: got %o want 4143", {bus.req_old_x, bus.req_old_y, bus.req_new_x, bus.req_new_y}); end
        n_cmp++; if (bus.req_piece_type !== 4'd5) begin n_fail++; $display("FAIL vm_type: got %0d want 5", bus.req_piece_type); end
        n_cmp++; if ({bus.req_active, move_done} !== 2'b10) begin n_fail++; $display("FAIL vm_T: got %b want 10", {bus.req_active, move_done}); end
        step(0, 0, 0, 0);
        n_cmp++; if ({bus.req_active, move_done} !== 2'b10) begin n_fail++; $display("FAIL vm_T1: got %b want 10", {bus.req_active, move_done}); end
        step(0, 0, 0, 0);
        n_cmp++; if ({move_done, move_rejected, bus.req_active, sel_active, turn} !== 5'b10001) begin n_fail++; $display("FAIL vm_T2_ctrl: got %b want 10001", {move_done, move_rejected, bus.req_active, sel_active, turn}); end
        n_cmp++; if ({bus.board[3][4], bus.board[1][4]} !== {4'd5, 4'd15}) begin n_fail++; $display("FAIL vm_T2_board: got %h want 5f", {bus.board[3][4], bus.board[1][4]}); end
        n_cmp++; if (bus.req_piece_type !== 4'd15) begin n_fail++; $display("FAIL vm_T2_type: got %0d want 15", bus.req_piece_type); end
        step(0, 0, 0, 0);
        n_cmp++; if (move_done !== 1'b0) begin n_fail++; $display("FAIL vm_T3_done: got %b want 0", move_done); end
    endtask

    task automatic test_illegal();
        apply_reset();
        step(1, 0, 0, 4);
        n_cmp++; if (sel_active !== 1'b0) begin n_fail++; $display("FAIL il_empty: got %b want 0", sel_active); end
        step(1, 0, 0, 6);
        n_cmp++; if (sel_active !== 1'b0) begin n_fail++; $display("FAIL il_opp: got %b want 0", sel_active); end
        step(1, 0, 1, 0);
        n_cmp++; if ({sel_active, sel_x, sel_y} !== {1'b1, 3'd1, 3'd0}) begin n_fail++; $display("FAIL il_own: got %b want 1_001_000", {sel_active, sel_x, sel_y}); end
        step(0, 1, 0, 0);
        n_cmp++; if (sel_active !== 1'b0) begin n_fail++; $display("FAIL il_cancel: got %b want 0", sel_active); end
        step(1, 0, 3, 4);
        n_cmp++; if ({sel_active, bus.req_active} !== 2'b00) begin n_fail++; $display("FAIL il_back_src: got %b want 00", {sel_active, bus.req_active}); end
    endtask

    task automatic test_reject();
        apply_reset();
        v_valid = 1'b0;
        step(1, 0, 1, 0);
        step(1, 0, 2, 2);
        n_cmp++; if ({bus.req_active, move_rejected} !== 2'b10) begin n_fail++; $display("FAIL rj_T: got %b want 10", {bus.req_active, move_rejected}); end
        step(0, 0, 0, 0);
        n_cmp++; if (move_rejected !== 1'b0) begin n_fail++; $display("FAIL rj_T1: got %b want 0", move_rejected); end
        step(0, 0, 0, 0);
        n_cmp++; if ({move_rejected, move_done, bus.req_active, turn} !== 4'b1000) begin n_fail++; $display("FAIL rj_T2: got %b want 1000", {move_rejected, move_done, bus.req_active, turn}); end
        n_cmp++; if (bus.board !== start_board()) begin n_fail++; $display("FAIL rj_board: got %h want %h", bus.board, start_board()); end
        step(0, 0, 0, 0);
        n_cmp++; if (move_rejected !== 1'b0) begin n_fail++; $display("FAIL rj_T3: got %b want 0", move_rejected); end
    endtask

    task automatic test_reselect();
        apply_reset();
        v_valid = 1'b0;
        step(1, 0, 1, 0);
        step(1, 0, 6, 0);
        n_cmp++; if ({sel_active, sel_x, sel_y, bus.req_active} !== {1'b1, 3'd6, 3'd0, 1'b0}) begin n_fail++; $display("FAIL rs_relatch: got %b want 1_110_000_0", {sel_active, sel_x, sel_y, bus.req_active}); end
        step(1, 0, 6, 0);
        n_cmp++; if (sel_active !== 1'b0) begin n_fail++; $display("FAIL rs_deselect: got %b want 0", sel_active); end
        step(1, 0, 6, 0);
        step(1, 0, 5, 2);
        step(1, 1, 0, 4);
        n_cmp++; if ({bus.req_active, bus.req_old_x, bus.req_old_y, bus.req_new_x, bus.req_new_y} !== {1'b1, 3'd6, 3'd0, 3'd5, 3'd2}) begin n_fail++; $display("FAIL rs_frozen: got %b want 1_110_000_101_010", {bus.req_active, bus.req_old_x, bus.req_old_y, bus.req_new_x, bus.req_new_y}); end
        step(1, 0, 3, 3);
        n_cmp++; if ({move_rejected, bus.req_active} !== 2'b10) begin n_fail++; $display("FAIL rs_result: got %b want 10", {move_rejected, bus.req_active}); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        v_valid = 1'b1;
        step(1, 0, 4, 1);
        step(1, 0, 4, 3);
        step(0, 0, 0, 0);
        #5 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.req_active, sel_active, turn, move_done} !== 4'b0000) begin n_fail++; $display("FAIL ar_ctrl: got %b want 0000", {bus.req_active, sel_active, turn, move_done}); end
        n_cmp++; if (bus.req_piece_type !== 4'd15) begin n_fail++; $display("FAIL ar_type: got %0d want 15", bus.req_piece_type); end
        n_cmp++; if (bus.board !== start_board()) begin n_fail++; $display("FAIL ar_board: got %h want %h", bus.board, start_board()); end
        @(posedge clk);
        #1;
        n_cmp++; if (move_done !== 1'b0) begin n_fail++; $display("FAIL ar_T2: got %b want 0", move_done); end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            n_cmp++; if ({move_done, turn} !== 2'b00) begin n_fail++; $display("FAIL ar_after_%0d: got %b want 00", i, {move_done, turn}); end
        end
        step(1, 0, 4, 1);
        step(1, 1, 4, 3);
        n_cmp++; if ({sel_active, bus.req_active} !== 2'b00) begin n_fail++; $display("FAIL sc_cancel: got %b want 00", {sel_active, bus.req_active}); end
        step(1, 0, 4, 3);
        n_cmp++; if ({sel_active, bus.req_active} !== 2'b00) begin n_fail++; $display("FAIL sc_in_src: got %b want 00", {sel_active, bus.req_active}); end
    endtask

    task automatic test_random();
        logic [31:0] act, exp;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            v_valid = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            act = {turn, bus.req_active, sel_active, sel_x, sel_y, bus.req_old_x, bus.req_old_y,
                   bus.req_new_x, bus.req_new_y, bus.req_piece_type, move_done, move_rejected, 3'b0};
            exp = {m_turn, m_ra, m_held, 3'(m_sx), 3'(m_sy), 3'(m_ox), 3'(m_oy),
                   3'(m_nx), 3'(m_ny), 4'(m_type), m_done, m_rej, 3'b0};
            n_cmp++; if (act !== exp) begin n_fail++; $display("FAIL rnd_ctrl cycle %0d: got %h want %h", i, act, exp); end
            n_cmp++; if (bus.board !== m_board) begin n_fail++; $display("FAIL rnd_board cycle %0d: got %h want %h", i, bus.board, m_board); end
        end
    endtask

    initial begin
        model_reset();
        v_valid = 1'b0;
        bus.val_board_out = '1;
        bus.val_board_valid = 1'b0;
        test_reset();
        test_valid_move();
        test_illegal();
        test_reject();
        test_reselect();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
